// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types for the memory arbiter (access sizes, FSM states, owners, alignment check)
package riscv_pkg;
    localparam int XLEN = 32;
    typedef enum logic [1:0] {MEM_BYTE = 2'b00, MEM_HALFW = 2'b01, MEM_WORD = 2'b10} mem_size_e;
    typedef enum logic [1:0] {ARB, WAIT_IF, WAIT_LS, ERR_LS} arb_state_e;
    typedef enum logic {OWNER_IF, OWNER_LS} arb_owner_e;
    function automatic logic is_misaligned(mem_size_e size, logic [1:0] addr);
        return (size == MEM_HALFW && addr[0]) || (size == MEM_WORD && addr != 2'b00);
    endfunction
endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: saturating count of cycles IF waited, flags when the limit is reached
//   clk_i/rst_ni: clock, async active-low reset; inc: count one wait cycle; clr: IF was granted
//   at_limit: count has reached LIMIT
module arb_starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt;
    assign at_limit = int'(cnt) >= LIMIT;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && !at_limit) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one memory port between instruction fetch (IF) and load/store (LS)
//   if_*  : IF word-read requester (req/gnt/rvalid/rdata)
//   ls_*  : LS read/write requester, ls_err_o flags misaligned accesses alongside ls_rvalid_o
//   mem_* : single-ported memory, one outstanding transaction
//   Build option ARB_STARVE_GUARD_EN: forces IF ahead after STARVE_LIMIT cycles of losing to LS.
module imem_dmem_arbiter
    import riscv_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [XLEN-1:0] if_rdata_o,
    input  logic            ls_req_i,
    input  logic            ls_we_i,
    input  mem_size_e       ls_size_i,
    input  logic [XLEN-1:0] ls_addr_i,
    input  logic [XLEN-1:0] ls_wdata_i,
    output logic            ls_gnt_o,
    output logic            ls_rvalid_o,
    output logic            ls_err_o,
    output logic [XLEN-1:0] ls_rdata_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output mem_size_e       mem_size_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);
    arb_state_e state, state_n;
    arb_owner_e owner, owner_n;
    logic lock, lock_n, force_if, sel_ls, has_req, mis, ls_mem_done;
    logic [XLEN-1:0] if_rdata_q, ls_rdata_q;

`ifdef ARB_STARVE_GUARD_EN
    logic at_limit;
    arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk_i,
        .rst_ni,
        .inc      (if_req_i && !if_gnt_o && (state == ARB || state == WAIT_LS)),
        .clr      (if_gnt_o),
        .at_limit
    );
    assign force_if = at_limit && if_req_i;
`else
    // STARVE_LIMIT has no effect without the guard; strict LS priority
    assign force_if = STARVE_LIMIT < 0;
`endif

    always_comb begin
        // a locked transaction keeps its owner regardless of the live requests
        sel_ls      = lock ? owner == OWNER_LS : ls_req_i && !force_if;
        has_req     = lock || sel_ls || if_req_i;
        mis         = state == ARB && sel_ls && is_misaligned(ls_size_i, ls_addr_i[1:0]);
        mem_req_o   = state == ARB && has_req && !mis;
        mem_we_o    = mem_req_o && sel_ls && ls_we_i;
        mem_size_o  = !mem_req_o ? MEM_BYTE : sel_ls ? ls_size_i : MEM_WORD;
        mem_addr_o  = !mem_req_o ? '0 : sel_ls ? ls_addr_i : if_addr_i;
        mem_wdata_o = mem_we_o ? ls_wdata_i : '0;
        if_gnt_o    = mem_req_o && mem_gnt_i && !sel_ls;
        ls_gnt_o    = mis || (mem_req_o && mem_gnt_i && sel_ls);
        ls_mem_done = state == WAIT_LS && mem_rvalid_i;
        if_rvalid_o = state == WAIT_IF && mem_rvalid_i;
        ls_rvalid_o = ls_mem_done || state == ERR_LS;
        ls_err_o    = state == ERR_LS;
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : if_rdata_q;
        ls_rdata_o  = ls_mem_done ? mem_rdata_i : ls_rdata_q;
        state_n     = state;
        owner_n     = owner;
        lock_n      = lock;
        case (state)
            ARB: begin
                if (mis) begin
                    state_n = ERR_LS;
                    lock_n  = 1'b0;
                end else if (mem_req_o) begin
                    owner_n = sel_ls ? OWNER_LS : OWNER_IF;
                    lock_n  = !mem_gnt_i;
                    state_n = !mem_gnt_i ? ARB : sel_ls ? WAIT_LS : WAIT_IF;
                end
            end
            WAIT_IF, WAIT_LS: state_n = mem_rvalid_i ? ARB : state;
            ERR_LS: state_n = ARB;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= ARB;
            owner      <= OWNER_IF;
            lock       <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            lock       <= lock_n;
            if_rdata_q <= if_rdata_o;
            ls_rdata_q <= ls_rdata_o;
        end
    end
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter: scoreboard bench for the IF/LS memory arbiter
module tb_imem_dmem_arbiter;
    import riscv_pkg::*;

    logic clk = 1'b0, rst_ni = 1'b0;
    logic if_req_i = 1'b0, if_gnt_o, if_rvalid_o;
    logic [31:0] if_addr_i = '0, if_rdata_o;
    logic ls_req_i = 1'b0, ls_we_i = 1'b0, ls_gnt_o, ls_rvalid_o, ls_err_o;
    mem_size_e ls_size_i = MEM_WORD, mem_size_o;
    logic [31:0] ls_addr_i = '0, ls_wdata_i = '0, ls_rdata_o;
    logic mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    logic gnt_hold = 1'b0, stray = 1'b0, p1 = 1'b0, p2 = 1'b0;
    logic [31:0] pend_addr = '0;

    typedef struct {logic is_ls; logic chk; logic [31:0] data; logic err;} exp_t;
    exp_t q[$];
    exp_t e;
    int checks = 0, errors = 0;

    imem_dmem_arbiter dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_size_i(ls_size_i),
        .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
        .ls_rvalid_o(ls_rvalid_o), .ls_err_o(ls_err_o), .ls_rdata_o(ls_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_size_o(mem_size_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    // memory: grant in the request cycle unless held off, completion two cycles later
    function automatic logic [31:0] rd(input logic [31:0] a);
        case ({a[31:2], 2'b00})
            32'h40:  return 32'h00500093;
            32'h200: return 32'h0BADC0DE;
            32'h300: return 32'hCAFEF00D;
            default: return ~a;
        endcase
    endfunction
    assign mem_gnt_i    = mem_req_o & ~gnt_hold;
    assign mem_rvalid_i = p2 | stray;
    assign mem_rdata_i  = rd(pend_addr);
    always @(posedge clk) begin
        p1 <= mem_req_o & mem_gnt_i;
        p2 <= p1;
        if (mem_req_o && mem_gnt_i) pend_addr <= mem_addr_o;
    end

    always @(negedge clk) begin
        if (if_rvalid_o || ls_rvalid_o) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid: if_rvalid=%0b ls_rvalid=%0b, required none", if_rvalid_o, ls_rvalid_o);
            end else begin
                e = q.pop_front();
                if ((if_rvalid_o && ls_rvalid_o) || ls_rvalid_o !== e.is_ls || ls_err_o !== e.err ||
                    (e.chk && (e.is_ls ? ls_rdata_o : if_rdata_o) !== e.data)) begin
                    errors++;
                    $display("FAIL completion: if_rv=%0b ls_rv=%0b err=%0b if_rdata=%h ls_rdata=%h, required ls=%0b err=%0b data=%h",
                             if_rvalid_o, ls_rvalid_o, ls_err_o, if_rdata_o, ls_rdata_o, e.is_ls, e.err, e.data);
                end
            end
        end
    end

    function automatic logic [136:0] outs();
        return {mem_req_o, mem_we_o, if_gnt_o, ls_gnt_o, if_rvalid_o, ls_rvalid_o, ls_err_o,
                mem_size_o, mem_addr_o, mem_wdata_o, if_rdata_o, ls_rdata_o};
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            #3;
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL wait_idle: %0d completions pending, required 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic grant_if();
        int n = 0;
        #1;
        while (!if_gnt_o && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (!if_gnt_o) begin
            errors++;
            $display("FAIL if_grant_timeout: if_gnt=%0b, required 1", if_gnt_o);
        end
        @(negedge clk);
        if_req_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (outs() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: %h, required 0", outs());
        end
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        checks++;
        if (outs() !== '0) begin
            errors++;
            $display("FAIL post_reset_outputs: %h, required 0", outs());
        end
        @(negedge clk);
    endtask

    task automatic test_if_only();
        if_req_i = 1'b1;
        if_addr_i = 32'h40;
        q.push_back('{1'b0, 1'b1, 32'h00500093, 1'b0});
        #1;
        checks++;
        if ({mem_req_o, if_gnt_o, ls_gnt_o, mem_we_o} !== 4'b1100) begin
            errors++;
            $display("FAIL if_issue: req/if_gnt/ls_gnt/we=%b, required 1100", {mem_req_o, if_gnt_o, ls_gnt_o, mem_we_o});
        end
        checks++;
        if (mem_addr_o !== 32'h40 || mem_size_o !== MEM_WORD) begin
            errors++;
            $display("FAIL if_fields: addr=%h size=%0d, required 40 size=%0d", mem_addr_o, mem_size_o, MEM_WORD);
        end
        @(negedge clk);
        if_req_i = 1'b0;
        wait_idle();
        checks++;
        if (if_rdata_o !== 32'h00500093) begin
            errors++;
            $display("FAIL if_rdata_hold: %h, required 00500093", if_rdata_o);
        end
    endtask

    task automatic test_both();
        if_req_i = 1'b1;
        if_addr_i = 32'h40;
        ls_req_i = 1'b1;
        ls_we_i = 1'b1;
        ls_size_i = MEM_WORD;
        ls_addr_i = 32'h100;
        ls_wdata_i = 32'hDEADBEEF;
        q.push_back('{1'b1, 1'b0, 32'h0, 1'b0});
        q.push_back('{1'b0, 1'b1, 32'h00500093, 1'b0});
        #1;
        checks++;
        if ({mem_we_o, ls_gnt_o, if_gnt_o} !== 3'b110 || mem_addr_o !== 32'h100 || mem_wdata_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL both_ls_first: we/ls_gnt/if_gnt=%b addr=%h wdata=%h, required 110 100 deadbeef",
                     {mem_we_o, ls_gnt_o, if_gnt_o}, mem_addr_o, mem_wdata_o);
        end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) ls_req_i = 1'b0;
            #1;
            checks++;
            if (if_gnt_o !== (c == 3) || (c == 3 && mem_addr_o !== 32'h40)) begin
                errors++;
                $display("FAIL both_if_after cycle %0d: if_gnt=%0b addr=%h, required %0b", c, if_gnt_o, mem_addr_o, c == 3);
            end
        end
        @(negedge clk);
        if_req_i = 1'b0;
        ls_we_i = 1'b0;
        wait_idle();
    endtask

    task automatic test_lock();
        gnt_hold = 1'b1;
        ls_req_i = 1'b1;
        ls_we_i = 1'b0;
        ls_size_i = MEM_WORD;
        ls_addr_i = 32'h200;
        if_req_i = 1'b1;
        if_addr_i = 32'h40;
        q.push_back('{1'b1, 1'b1, 32'h0BADC0DE, 1'b0});
        q.push_back('{1'b0, 1'b1, 32'h00500093, 1'b0});
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin
                gnt_hold = 1'b0;
                ls_req_i = 1'b0;
            end
            #1;
            checks++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200 || ls_gnt_o !== (c == 4) || if_gnt_o !== 1'b0) begin
                errors++;
                $display("FAIL lock cycle %0d: req=%0b addr=%h ls_gnt=%0b if_gnt=%0b, required 1 200 %0b 0",
                         c, mem_req_o, mem_addr_o, ls_gnt_o, if_gnt_o, c == 4);
            end
            @(negedge clk);
        end
        grant_if();
        wait_idle();
    endtask

    task automatic test_misaligned();
        mem_size_e sz[4] = '{MEM_WORD, MEM_HALFW, MEM_HALFW, MEM_BYTE};
        logic [31:0] ad[4] = '{32'h102, 32'h301, 32'h302, 32'h303};
        logic ms[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            ls_req_i = 1'b1;
            ls_we_i = 1'b0;
            ls_size_i = sz[i];
            ls_addr_i = ad[i];
            q.push_back(ms[i] ? '{1'b1, 1'b0, 32'h0, 1'b1} : '{1'b1, 1'b1, 32'hCAFEF00D, 1'b0});
            #1;
            checks++;
            if (mem_req_o !== !ms[i] || ls_gnt_o !== 1'b1) begin
                errors++;
                $display("FAIL align %0d: mem_req=%0b ls_gnt=%0b, required %0b 1", i, mem_req_o, ls_gnt_o, !ms[i]);
            end
            @(negedge clk);
            ls_req_i = 1'b0;
            #1;
            checks++;
            if (mem_req_o !== 1'b0) begin
                errors++;
                $display("FAIL align_after %0d: mem_req=%0b, required 0", i, mem_req_o);
            end
            wait_idle();
        end
    endtask

    task automatic test_starve();
        int first = -1;
        int gnts = 0;
        ls_req_i = 1'b1;
        ls_we_i = 1'b0;
        ls_size_i = MEM_WORD;
        ls_addr_i = 32'h300;
        if_req_i = 1'b1;
        if_addr_i = 32'h40;
`ifdef ARB_STARVE_GUARD_EN
        for (int c = 0; c < 60 && first < 0; c++) begin
            #1;
            if (ls_gnt_o) q.push_back('{1'b1, 1'b1, 32'hCAFEF00D, 1'b0});
            if (if_gnt_o) first = c;
            @(negedge clk);
        end
        ls_req_i = 1'b0;
        if_req_i = 1'b0;
        q.push_back('{1'b0, 1'b1, 32'h00500093, 1'b0});
        checks++;
        if (first != 6) begin
            errors++;
            $display("FAIL starve_guard: IF granted at cycle %0d, required 6", first);
        end
`else
        for (int c = 0; c < 50; c++) begin
            #1;
            if (ls_gnt_o) q.push_back('{1'b1, 1'b1, 32'hCAFEF00D, 1'b0});
            if (if_gnt_o) gnts++;
            @(negedge clk);
        end
        checks++;
        if (gnts != 0) begin
            errors++;
            $display("FAIL strict_priority: IF granted %0d times, required 0", gnts);
        end
        ls_req_i = 1'b0;
        q.push_back('{1'b0, 1'b1, 32'h00500093, 1'b0});
        grant_if();
`endif
        wait_idle();
    endtask

    task automatic test_reset_mid();
        ls_req_i = 1'b1;
        ls_we_i = 1'b0;
        ls_size_i = MEM_WORD;
        ls_addr_i = 32'h300;
        @(negedge clk);
        ls_req_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (outs() !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: %h, required 0", outs());
        end
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        checks++;
        if (outs() !== '0 || mem_rvalid_i !== 1'b1) begin
            errors++;
            $display("FAIL late_rvalid: outs=%h mem_rvalid=%0b, required 0 with late rvalid 1", outs(), mem_rvalid_i);
        end
        @(negedge clk);
        stray = 1'b1;
        #1;
        checks++;
        if (outs() !== '0) begin
            errors++;
            $display("FAIL stray_rvalid: %h, required 0", outs());
        end
        @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_if_only();
        test_both();
        test_lock();
        test_misaligned();
        test_starve();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule
